// File: rtl/cell_proc_arbiter_if.sv
// rtl/cell_proc_arbiter_if.sv - requester, CellProcessor and response signals of the arbiter.
interface cell_proc_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int IW_W    = 128,
   parameter int PIX_W   = 8
);
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ*IW_W-1:0] req_iw;
   logic [NUM_REQ-1:0]      req_ready;
   logic [IW_W-1:0]         cp_iw;
   logic [PIX_W-1:0]        cp_result;
   logic                    resp_valid;
   logic                    resp_ready;
   logic [ID_W-1:0]         resp_id;
   logic [PIX_W-1:0]        resp_pixel;

   // master is the surrounding system (requesters, processor, consumer)
   modport master (
      output req_valid, req_iw, cp_result, resp_ready,
      input  req_ready, cp_iw, resp_valid, resp_id, resp_pixel
   );

   modport slave (
      input  req_valid, req_iw, cp_result, resp_ready,
      output req_ready, cp_iw, resp_valid, resp_id, resp_pixel
   );
endinterface

// File: rtl/cell_proc_arbiter.sv
// rtl/cell_proc_arbiter.sv - round-robin sharing of one CellProcessor between NUM_REQ requesters.
// Optional per-requester grant and stall counters when CELL_ARB_STATS_EN is defined.
module cell_proc_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int IW_W    = 128,
   parameter int PIX_W   = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   cell_proc_arbiter_if.slave      bus,
   output logic                    cp_rst,
   output logic                    busy
`ifdef CELL_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]   stat_grants,
   output logic [15:0]             stat_stall
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e            state_q;
   logic [IW_W-1:0]   iw_q;
   logic [ID_W-1:0]   id_q;
   logic [ID_W-1:0]   last_q;
   logic [PIX_W-1:0]  res_q;
   logic              resp_valid_q;
   logic              busy_q;

   logic [ID_W-1:0]   win;
   logic              any_req;
   logic              grant_en;
   logic              accept;

   // Scan from the farthest candidate down so the nearest one after last_q wins.
   always_comb begin
      win     = '0;
      any_req = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (bus.req_valid[ID_W'((int'(last_q) + k) % NUM_REQ)]) begin
            win     = ID_W'((int'(last_q) + k) % NUM_REQ);
            any_req = 1'b1;
         end
      end
   end

   assign grant_en      = (state_q == IDLE) || (state_q == RESP && bus.resp_ready);
   assign accept        = grant_en && any_req && !rst;
   assign bus.req_ready = accept ? (NUM_REQ'(1) << win) : '0;

   assign bus.cp_iw      = iw_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_id    = id_q;
   assign bus.resp_pixel = res_q;
   assign busy           = busy_q;
   assign cp_rst         = rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         iw_q         <= '0;
         id_q         <= '0;
         last_q       <= ID_W'(NUM_REQ - 1);
         res_q        <= '0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         if (accept) begin
            iw_q   <= bus.req_iw[win*IW_W +: IW_W];
            id_q   <= win;
            last_q <= win;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= EXEC;
                  busy_q  <= 1'b1;
               end
            end
            EXEC: begin
               res_q        <= bus.cp_result;
               resp_valid_q <= 1'b1;
               state_q      <= RESP;
            end
            RESP: begin
               // A new grant may ride on the same edge as the response handshake.
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  busy_q       <= accept;
                  state_q      <= accept ? EXEC : IDLE;
               end
            end
            default: begin
               state_q      <= IDLE;
               resp_valid_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

`ifdef CELL_ARB_STATS_EN
   logic [15:0] grant_cnt_q [NUM_REQ];
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_q[i] <= '0;
         end
         stall_q <= '0;
      end else begin
         if (accept && grant_cnt_q[win] != 16'hFFFF) begin
            grant_cnt_q[win] <= grant_cnt_q[win] + 16'd1;
         end
         if (state_q == RESP && !bus.resp_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
      assign stat_grants[g*16 +: 16] = grant_cnt_q[g];
   end
   assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_cell_proc_arbiter.sv
// tb/tb_cell_proc_arbiter.sv - directed-vector bench for cell_proc_arbiter with a toy CellProcessor model.
module tb_cell_proc_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int IW_W    = 128;
   localparam int PIX_W   = 8;
   localparam logic [7:0] OP_ADDI = 8'h11;
   localparam logic [7:0] OP_SUB  = 8'h22;

   logic clk = 1'b0;
   logic rst;
   logic cp_rst;
   logic busy;
`ifdef CELL_ARB_STATS_EN
   logic [NUM_REQ*16-1:0] stat_grants;
   logic [15:0]           stat_stall;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   cell_proc_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .IW_W(IW_W), .PIX_W(PIX_W)) bus ();

   cell_proc_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .IW_W(IW_W), .PIX_W(PIX_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .cp_rst      (cp_rst),
      .busy        (busy)
`ifdef CELL_ARB_STATS_EN
      ,
      .stat_grants (stat_grants),
      .stat_stall  (stat_stall)
`endif
   );

   always #5 clk = ~clk;

   // Toy instruction word: [7:0] op, [15:8] cellA centre, [23:16] cellB centre, [31:24] userInputA.
   always_comb begin
      case (bus.cp_iw[7:0])
         OP_ADDI: bus.cp_result = bus.cp_iw[15:8] + bus.cp_iw[31:24];
         OP_SUB:  bus.cp_result = bus.cp_iw[15:8] - bus.cp_iw[23:16];
         default: bus.cp_result = '0;
      endcase
   end

   function automatic logic [IW_W-1:0] mk_iw(input logic [7:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] u);
      logic [IW_W-1:0] w;
      w          = '0;
      w[7:0]     = op;
      w[15:8]    = a;
      w[23:16]   = b;
      w[31:24]   = u;
      w[127:120] = a ^ 8'h5A;
      return w;
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.req_valid = '0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [IW_W-1:0] iw_a;

   initial begin
      rst            = 1'b1;
      bus.req_valid  = 4'b1111;
      bus.req_iw     = '0;
      bus.resp_ready = 1'b0;
      tick();
      tick();
      settle();
      check("rst_req_ready",  128'(bus.req_ready),  128'(0));
      check("rst_resp_valid", 128'(bus.resp_valid), 128'(0));
      check("rst_resp_pixel", 128'(bus.resp_pixel), 128'(0));
      check("rst_resp_id",    128'(bus.resp_id),    128'(0));
      check("rst_busy",       128'(busy),           128'(0));
      check("rst_cp_iw",      128'(bus.cp_iw),      128'(0));
      check("rst_cp_rst",     128'(cp_rst),         128'(1));

      // Single request: ADDI 10 + 5.
      rst            = 1'b0;
      iw_a           = mk_iw(OP_ADDI, 8'd10, 8'd0, 8'd5);
      bus.req_iw[0 +: IW_W] = iw_a;
      bus.req_valid  = 4'b0001;
      bus.resp_ready = 1'b1;
      settle();
      check("t1_req_ready", 128'(bus.req_ready), 128'(4'b0001));
      tick();
      bus.req_valid = '0;
      settle();
      check("t1_exec_busy",  128'(busy),           128'(1));
      check("t1_exec_valid", 128'(bus.resp_valid), 128'(0));
      check("t1_exec_cp_iw", 128'(bus.cp_iw),      128'(iw_a));
      tick();
      settle();
      check("t1_resp_valid", 128'(bus.resp_valid), 128'(1));
      check("t1_resp_pixel", 128'(bus.resp_pixel), 128'(15));
      check("t1_resp_id",    128'(bus.resp_id),    128'(0));
      tick();
      settle();
      check("t1_idle_busy",  128'(busy),           128'(0));
      check("t1_idle_valid", 128'(bus.resp_valid), 128'(0));
      check("t1_idle_cp_iw", 128'(bus.cp_iw),      128'(iw_a));

      // Fairness: all four pending, requester i computes 10*i + 1.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_iw[i*IW_W +: IW_W] = mk_iw(OP_ADDI, 8'(10 * i), 8'd0, 8'd1);
      end
      bus.req_valid  = 4'b1111;
      bus.resp_ready = 1'b1;
      for (int op = 0; op < 8; op++) begin
         settle();
         check("fair_grant", 128'(bus.req_ready), 128'(4'b0001 << (op % 4)));
         if (op > 0) begin
            check("fair_resp_valid", 128'(bus.resp_valid), 128'(1));
            check("fair_resp_id",    128'(bus.resp_id),    128'((op - 1) % 4));
            check("fair_resp_pixel", 128'(bus.resp_pixel), 128'(10 * ((op - 1) % 4) + 1));
         end
         tick();
         if (op == 7) bus.req_valid = '0;
         settle();
         check("fair_exec_ready", 128'(bus.req_ready),  128'(0));
         check("fair_exec_valid", 128'(bus.resp_valid), 128'(0));
         tick();
      end
      settle();
      check("fair_last_id",    128'(bus.resp_id),    128'(3));
      check("fair_last_pixel", 128'(bus.resp_pixel), 128'(31));
      bus.resp_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         tick();
         settle();
         check("fair_stall_valid", 128'(bus.resp_valid), 128'(1));
      end
`ifdef CELL_ARB_STATS_EN
      for (int i = 0; i < NUM_REQ; i++) begin
         check("stat_grants", 128'(stat_grants[i*16 +: 16]), 128'(2));
      end
      check("stat_stall", 128'(stat_stall), 128'(3));
`endif
      bus.resp_ready = 1'b1;
      tick();
      settle();
      check("fair_idle_valid", 128'(bus.resp_valid), 128'(0));
      check("fair_idle_busy",  128'(busy),           128'(0));

      // Backpressure: SUB 40 - 15 held for 5 cycles with requester 1 waiting.
      bus.req_iw[0 +: IW_W] = mk_iw(OP_SUB, 8'd40, 8'd15, 8'd0);
      bus.req_valid  = 4'b0001;
      bus.resp_ready = 1'b0;
      settle();
      check("bp_grant", 128'(bus.req_ready), 128'(4'b0001));
      tick();
      bus.req_valid = 4'b0010;
      tick();
      for (int s = 0; s < 5; s++) begin
         settle();
         check("bp_valid", 128'(bus.resp_valid), 128'(1));
         check("bp_pixel", 128'(bus.resp_pixel), 128'(25));
         check("bp_ready", 128'(bus.req_ready),  128'(0));
         tick();
      end
      bus.req_valid  = '0;
      bus.resp_ready = 1'b1;
      settle();
      check("bp_hs_valid", 128'(bus.resp_valid), 128'(1));
      check("bp_hs_pixel", 128'(bus.resp_pixel), 128'(25));
      tick();
      settle();
      check("bp_done_valid", 128'(bus.resp_valid), 128'(0));
      check("bp_done_busy",  128'(busy),           128'(0));

      // Back-to-back: requesters 1 (20 + 7) and 2 (50 - 8).
      do_reset();
      settle();
`ifdef CELL_ARB_STATS_EN
      for (int i = 0; i < NUM_REQ; i++) begin
         check("stat_grants_clr", 128'(stat_grants[i*16 +: 16]), 128'(0));
      end
      check("stat_stall_clr", 128'(stat_stall), 128'(0));
`endif
      bus.req_iw[1*IW_W +: IW_W] = mk_iw(OP_ADDI, 8'd20, 8'd0, 8'd7);
      bus.req_iw[2*IW_W +: IW_W] = mk_iw(OP_SUB, 8'd50, 8'd8, 8'd0);
      bus.req_valid  = 4'b0110;
      bus.resp_ready = 1'b1;
      settle();
      check("b2b_grant1", 128'(bus.req_ready), 128'(4'b0010));
      tick();
      bus.req_valid = 4'b0100;
      settle();
      check("b2b_exec1_valid", 128'(bus.resp_valid), 128'(0));
      tick();
      settle();
      check("b2b_resp1_valid", 128'(bus.resp_valid), 128'(1));
      check("b2b_resp1_id",    128'(bus.resp_id),    128'(1));
      check("b2b_resp1_pixel", 128'(bus.resp_pixel), 128'(27));
      check("b2b_grant2",      128'(bus.req_ready),  128'(4'b0100));
      tick();
      bus.req_valid = '0;
      settle();
      check("b2b_exec2_valid", 128'(bus.resp_valid), 128'(0));
      check("b2b_exec2_busy",  128'(busy),           128'(1));
      tick();
      settle();
      check("b2b_resp2_valid", 128'(bus.resp_valid), 128'(1));
      check("b2b_resp2_id",    128'(bus.resp_id),    128'(2));
      check("b2b_resp2_pixel", 128'(bus.resp_pixel), 128'(42));
      tick();

      // Reset while requester 3 is in EXEC.
      bus.req_iw[3*IW_W +: IW_W] = mk_iw(OP_ADDI, 8'd1, 8'd0, 8'd2);
      bus.req_valid = 4'b1000;
      settle();
      check("mr_grant3", 128'(bus.req_ready), 128'(4'b1000));
      tick();
      bus.req_valid = '0;
      settle();
      check("mr_exec_busy", 128'(busy), 128'(1));
      rst = 1'b1;
      tick();
      rst           = 1'b0;
      bus.req_valid = 4'b1111;
      settle();
      check("mr_valid", 128'(bus.resp_valid), 128'(0));
      check("mr_busy",  128'(busy),           128'(0));
      check("mr_cp_iw", 128'(bus.cp_iw),      128'(0));
      check("mr_next",  128'(bus.req_ready),  128'(4'b0001));
`ifdef CELL_ARB_STATS_EN
      check("mr_stat_stall", 128'(stat_stall), 128'(0));
`endif
      tick();
      bus.req_valid = '0;
      settle();
      check("mr_exec0_valid", 128'(bus.resp_valid), 128'(0));
      tick();
      settle();
      check("mr_resp0_valid", 128'(bus.resp_valid), 128'(1));
      check("mr_resp0_id",    128'(bus.resp_id),    128'(0));
      check("mr_resp0_pixel", 128'(bus.resp_pixel), 128'(25));
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
